// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one synchronous memory port between a CPU
// (read/write) and a video fetcher (read only), round-robin on ties.
module mem_arbiter #(
   parameter int AW = 16,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [DW-1:0] vid_rdata,
   output logic          vid_ack,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DONE
   } state_t;

   state_t state;
   logic   owner_vid;
   logic   last_vid;
   logic   grant_vid;

   // A lone requester always wins; on a tie the side not served last wins.
   always_comb begin
      grant_vid = 1'b0;
      if (vid_req && !cpu_req) begin
         grant_vid = 1'b1;
      end else if (vid_req && cpu_req) begin
         grant_vid = !last_vid;
      end
   end

   // mem_addr/mem_wdata double as the latched request fields, so later changes
   // on the requester side cannot disturb an access in flight. Read data is
   // taken at the end of ADDR, when the memory answers the registered address,
   // so the ack and its data appear together in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner_vid <= 1'b0;
         last_vid  <= 1'b1;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         cpu_rdata <= '0;
         vid_rdata <= '0;
         cpu_ack   <= 1'b0;
         vid_ack   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         vid_ack <= 1'b0;
         mem_we  <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req || vid_req) begin
                  owner_vid <= grant_vid;
                  mem_addr  <= grant_vid ? vid_addr : cpu_addr;
                  mem_wdata <= grant_vid ? '0 : cpu_wdata;
                  mem_we    <= !grant_vid && cpu_we;
                  busy      <= 1'b1;
                  state     <= ADDR;
               end
            end
            ADDR: begin
               if (owner_vid) begin
                  vid_rdata <= mem_rdata;
                  vid_ack   <= 1'b1;
               end else begin
                  cpu_rdata <= mem_rdata;
                  cpu_ack   <= 1'b1;
               end
               last_vid <= owner_vid;
               state    <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run compared against a transaction-schedule reference model.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic        vid_req;
   logic [15:0] vid_addr;
   logic [7:0]  vid_rdata;
   logic        vid_ack;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;
   logic        busy;

   int tests;
   int fails;

   logic [7:0] mem [0:65535];
   logic [7:0] ref_mem [0:15];

   mem_arbiter #(.AW(16), .DW(8)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
      .vid_ack(vid_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory answers the registered address; writes land on the clock edge.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0042; cpu_wdata = 8'hEE;
      vid_req = 1'b1; vid_addr = 16'h0043;
      tick();
      tick();
      vid_req = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
      tests++; if (mem_we !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_we: got %b, expected 0", mem_we); end
      tests++; if (cpu_ack !== 1'b0 || vid_ack !== 1'b0) begin fails++; $display("[TB] FAIL reset_acks: got %b%b, expected 00", cpu_ack, vid_ack); end
      tests++; if (mem_addr !== 16'h0000) begin fails++; $display("[TB] FAIL reset_mem_addr: got %h, expected 0000", mem_addr); end
      tests++; if (mem_wdata !== 8'h00) begin fails++; $display("[TB] FAIL reset_mem_wdata: got %h, expected 00", mem_wdata); end
      tests++; if (cpu_rdata !== 8'h00 || vid_rdata !== 8'h00) begin fails++; $display("[TB] FAIL reset_rdata: got %h/%h, expected 00/00", cpu_rdata, vid_rdata); end
      cpu_we = 1'b0;
      mem[16'h0042] = 8'h3C;
      rst = 1'b0;
      tick();
      tests++; if (busy !== 1'b1 || mem_addr !== 16'h0042) begin fails++; $display("[TB] FAIL reset_resume: got busy=%b addr=%h, expected busy=1 addr=0042", busy, mem_addr); end
      tick();
      tests++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h3C) begin fails++; $display("[TB] FAIL reset_resume_ack: got ack=%b data=%h, expected ack=1 data=3c", cpu_ack, cpu_rdata); end
      cpu_req = 1'b0;
      tick();
   endtask

   task automatic test_cpu_read();
      mem[16'h1234] = 8'h5A;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 8'h00;
      tick();
      tests++; if (mem_addr !== 16'h1234 || mem_we !== 1'b0 || busy !== 1'b1) begin fails++; $display("[TB] FAIL cpu_read_addr: got addr=%h we=%b busy=%b, expected 1234/0/1", mem_addr, mem_we, busy); end
      tests++; if (cpu_ack !== 1'b0) begin fails++; $display("[TB] FAIL cpu_read_early_ack: got %b, expected 0", cpu_ack); end
      tick();
      tests++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A) begin fails++; $display("[TB] FAIL cpu_read_ack: got ack=%b data=%h, expected 1/5a", cpu_ack, cpu_rdata); end
      tests++; if (vid_ack !== 1'b0) begin fails++; $display("[TB] FAIL cpu_read_vid_ack: got %b, expected 0", vid_ack); end
      cpu_req = 1'b0;
      tick();
      tests++; if (cpu_ack !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL cpu_read_end: got ack=%b busy=%b, expected 0/0", cpu_ack, busy); end
      tick();
   endtask

   task automatic test_cpu_write();
      mem[16'h0010] = 8'h00;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hC3;
      tick();
      tests++; if (mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 8'hC3) begin fails++; $display("[TB] FAIL cpu_write_strobe: got we=%b addr=%h data=%h, expected 1/0010/c3", mem_we, mem_addr, mem_wdata); end
      tick();
      tests++; if (mem_we !== 1'b0 || cpu_ack !== 1'b1) begin fails++; $display("[TB] FAIL cpu_write_ack: got we=%b ack=%b, expected 0/1", mem_we, cpu_ack); end
      cpu_req = 1'b0; cpu_we = 1'b0;
      tick();
      vid_req = 1'b1; vid_addr = 16'h0010;
      tick();
      tests++; if (mem_we !== 1'b0 || mem_addr !== 16'h0010) begin fails++; $display("[TB] FAIL vid_after_write_addr: got we=%b addr=%h, expected 0/0010", mem_we, mem_addr); end
      tick();
      tests++; if (vid_ack !== 1'b1 || vid_rdata !== 8'hC3 || cpu_ack !== 1'b0) begin fails++; $display("[TB] FAIL vid_after_write_data: got ack=%b data=%h cpu_ack=%b, expected 1/c3/0", vid_ack, vid_rdata, cpu_ack); end
      vid_req = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic exp_cpu;
      logic exp_vid;
      do_reset();
      mem[16'h0001] = 8'h11;
      mem[16'h0002] = 8'h22;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
      vid_req = 1'b1; vid_addr = 16'h0002;
      for (int j = 0; j < 9; j++) begin
         tick();
         exp_cpu = (j == 1) || (j == 7);
         exp_vid = (j == 4);
         tests++; if (cpu_ack !== exp_cpu || vid_ack !== exp_vid) begin fails++; $display("[TB] FAIL alternation_j%0d: got cpu_ack=%b vid_ack=%b, expected %b/%b", j, cpu_ack, vid_ack, exp_cpu, exp_vid); end
         if (j == 4) begin
            tests++; if (vid_rdata !== 8'h22) begin fails++; $display("[TB] FAIL alternation_vid_data: got %h, expected 22", vid_rdata); end
         end
      end
      tests++; if (cpu_rdata !== 8'h11) begin fails++; $display("[TB] FAIL alternation_cpu_data: got %h, expected 11", cpu_rdata); end
      cpu_req = 1'b0; vid_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_vid_read();
      mem[16'h8000] = 8'h77;
      vid_req = 1'b1; vid_addr = 16'h8000;
      tick();
      tests++; if (mem_addr !== 16'h8000 || busy !== 1'b1) begin fails++; $display("[TB] FAIL vid_read_addr: got addr=%h busy=%b, expected 8000/1", mem_addr, busy); end
      tick();
      tests++; if (vid_ack !== 1'b1 || vid_rdata !== 8'h77) begin fails++; $display("[TB] FAIL vid_read_ack: got ack=%b data=%h, expected 1/77", vid_ack, vid_rdata); end
      tests++; if (cpu_rdata !== 8'h11 || cpu_ack !== 1'b0) begin fails++; $display("[TB] FAIL vid_read_cpu_hold: got data=%h ack=%b, expected 11/0", cpu_rdata, cpu_ack); end
      vid_req = 1'b0;
      tick();
   endtask

   task automatic test_addr_change();
      mem[16'h0100] = 8'hAB;
      mem[16'h0200] = 8'hCD;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
      tick();
      cpu_addr = 16'h0200; cpu_we = 1'b1; cpu_wdata = 8'h55;
      tests++; if (mem_addr !== 16'h0100) begin fails++; $display("[TB] FAIL addr_change_grant: got %h, expected 0100", mem_addr); end
      tick();
      tests++; if (mem_addr !== 16'h0100 || cpu_rdata !== 8'hAB || mem_we !== 1'b0) begin fails++; $display("[TB] FAIL addr_change_hold: got addr=%h data=%h we=%b, expected 0100/ab/0", mem_addr, cpu_rdata, mem_we); end
      cpu_req = 1'b0; cpu_we = 1'b0;
      tick();
   endtask

   task automatic test_reset_abort();
      mem[16'h0020] = 8'h00;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'h99;
      tick();
      tests++; if (mem_we !== 1'b1) begin fails++; $display("[TB] FAIL abort_strobe: got %b, expected 1", mem_we); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++; if (cpu_ack !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_state: got ack=%b we=%b busy=%b, expected 0/0/0", cpu_ack, mem_we, busy); end
      cpu_we = 1'b0; cpu_addr = 16'h0031;
      vid_req = 1'b1; vid_addr = 16'h0032;
      tick();
      tests++; if (mem_addr !== 16'h0031 || cpu_ack !== 1'b0) begin fails++; $display("[TB] FAIL abort_tie_grant: got addr=%h ack=%b, expected 0031/0", mem_addr, cpu_ack); end
      tick();
      tests++; if (cpu_ack !== 1'b1 || vid_ack !== 1'b0) begin fails++; $display("[TB] FAIL abort_tie_ack: got cpu=%b vid=%b, expected 1/0", cpu_ack, vid_ack); end
      cpu_req = 1'b0; vid_req = 1'b0;
      tick();
      tick();
   endtask

   // Reference: each grant occupies three edges; ack and data follow the grant
   // by one edge; ties go to whichever side was not served last.
   task automatic test_random();
      int          gk;
      int          ak;
      int          freek;
      logic        m_vid;
      logic        m_we;
      logic        last_vid;
      logic [15:0] m_addr;
      logic [7:0]  m_wdata;
      logic [7:0]  rd;
      logic [7:0]  e_cpu_rdata;
      logic [7:0]  e_vid_rdata;
      logic        e_cpu_ack;
      logic        e_vid_ack;
      logic        e_busy;
      logic        e_mem_we;
      cpu_req = 1'b0; vid_req = 1'b0;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         rd = 8'($urandom);
         mem[i] = rd;
         ref_mem[i] = rd;
      end
      gk = -10; ak = -10; freek = 0;
      m_vid = 1'b0; m_we = 1'b0; m_addr = 16'h0000; m_wdata = 8'h00;
      last_vid = 1'b1; e_cpu_rdata = 8'h00; e_vid_rdata = 8'h00;
      for (int k = 0; k < 800; k++) begin
         if ((!cpu_req && $urandom_range(2) == 0) || (cpu_req && $urandom_range(3) == 0)) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom_range(1));
            cpu_addr = 16'($urandom_range(15)); cpu_wdata = 8'($urandom);
         end
         if ((!vid_req && $urandom_range(2) == 0) || (vid_req && $urandom_range(3) == 0)) begin
            vid_req = 1'b1; vid_addr = 16'($urandom_range(15));
         end
         e_cpu_ack = 1'b0;
         e_vid_ack = 1'b0;
         if (k == ak) begin
            rd = ref_mem[m_addr[3:0]];
            if (m_we) ref_mem[m_addr[3:0]] = m_wdata;
            if (m_vid) begin e_vid_ack = 1'b1; e_vid_rdata = rd; end
            else begin e_cpu_ack = 1'b1; e_cpu_rdata = rd; end
            last_vid = m_vid;
         end
         if (k >= freek && (cpu_req || vid_req)) begin
            m_vid   = (cpu_req && vid_req) ? !last_vid : vid_req;
            m_addr  = m_vid ? vid_addr : cpu_addr;
            m_we    = !m_vid && cpu_we;
            m_wdata = cpu_wdata;
            gk = k; ak = k + 1; freek = k + 3;
         end
         e_busy   = (k - gk) <= 1;
         e_mem_we = (k == gk) && m_we;
         tick();
         tests++; if (cpu_ack !== e_cpu_ack || vid_ack !== e_vid_ack) begin fails++; $display("[TB] FAIL rand_ack_k%0d: got cpu=%b vid=%b, expected %b/%b", k, cpu_ack, vid_ack, e_cpu_ack, e_vid_ack); end
         tests++; if (busy !== e_busy || mem_we !== e_mem_we) begin fails++; $display("[TB] FAIL rand_busy_we_k%0d: got busy=%b we=%b, expected %b/%b", k, busy, mem_we, e_busy, e_mem_we); end
         tests++; if (mem_addr !== m_addr) begin fails++; $display("[TB] FAIL rand_addr_k%0d: got %h, expected %h", k, mem_addr, m_addr); end
         tests++; if (cpu_rdata !== e_cpu_rdata || vid_rdata !== e_vid_rdata) begin fails++; $display("[TB] FAIL rand_rdata_k%0d: got %h/%h, expected %h/%h", k, cpu_rdata, vid_rdata, e_cpu_rdata, e_vid_rdata); end
         if (e_mem_we) begin
            tests++; if (mem_wdata !== m_wdata) begin fails++; $display("[TB] FAIL rand_wdata_k%0d: got %h, expected %h", k, mem_wdata, m_wdata); end
         end
         if (e_cpu_ack && $urandom_range(3) != 0) cpu_req = 1'b0;
         if (e_vid_ack && $urandom_range(3) != 0) vid_req = 1'b0;
      end
      cpu_req = 1'b0; vid_req = 1'b0;
      tick();
      tick();
      tick();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
      vid_req = 1'b0; vid_addr = 16'h0000;
      #2;
      test_reset();
      test_cpu_read();
      test_cpu_write();
      test_back_to_back();
      test_vid_read();
      test_addr_change();
      test_reset_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
